// File: rtl/morse_player_if.sv
// Start/busy/done handshake between the digit sequencer and the Morse player.
// The sequencer drives start and morse_in. The player reports busy and a one-cycle done pulse.
interface morse_player_if;
    logic       start;
    logic [4:0] morse_in;
    logic       busy;
    logic       done;

    modport master (output start, output morse_in, input busy, input done);
    modport slave  (input start, input morse_in, output busy, output done);
endinterface

// File: rtl/morse_player.sv
// Plays one 5-element Morse pattern (bit=1 dot, bit 0 first) on tone/ponto/traco; `MORSE_LOOP_EN adds loop replay.
// Latency: the first MARK cycle follows the edge that accepts start; done pulses on the first cycle after the gap.
// Backpressure: start is honoured only in IDLE (including the done cycle); it is dropped while busy, with no queueing.
module morse_player #(
    parameter int UNIT_CYCLES    = 12500000,
    parameter int DASH_UNITS     = 3,
    parameter int CHAR_GAP_UNITS = 3
) (
    input  logic          clk,
    input  logic          reset,
    morse_player_if.slave seq,
`ifdef MORSE_LOOP_EN
    input  logic          loop_en,
`endif
    output logic          tone,
    output logic          ponto,
    output logic          traco,
    output logic [2:0]    sym_idx
);

    localparam int MAX_UNITS = (DASH_UNITS > CHAR_GAP_UNITS) ? DASH_UNITS : CHAR_GAP_UNITS;
    localparam int TW_RAW    = $clog2(MAX_UNITS * UNIT_CYCLES);
    localparam int TW        = (TW_RAW < 1) ? 1 : TW_RAW;

    localparam logic [TW-1:0] DOT_LOAD  = TW'(UNIT_CYCLES - 1);
    localparam logic [TW-1:0] DASH_LOAD = TW'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE, S_GAP} state_t;

    state_t        state;
    logic [4:0]    pat;
    logic [TW-1:0] timer;
`ifdef MORSE_LOOP_EN
    logic [4:0]    pat_orig;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            pat       <= '0;
            timer     <= '0;
            tone      <= 1'b0;
            ponto     <= 1'b0;
            traco     <= 1'b0;
            sym_idx   <= 3'd0;
            seq.busy  <= 1'b0;
            seq.done  <= 1'b0;
`ifdef MORSE_LOOP_EN
            pat_orig  <= '0;
`endif
        end else begin
            seq.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (seq.start) begin
                        pat      <= seq.morse_in;
`ifdef MORSE_LOOP_EN
                        pat_orig <= seq.morse_in;
`endif
                        sym_idx  <= 3'd0;
                        timer    <= seq.morse_in[0] ? DOT_LOAD : DASH_LOAD;
                        state    <= S_MARK;
                        tone     <= 1'b1;
                        ponto    <= seq.morse_in[0];
                        traco    <= ~seq.morse_in[0];
                        seq.busy <= 1'b1;
                    end
                end
                S_MARK: begin
                    if (timer == '0) begin
                        tone  <= 1'b0;
                        ponto <= 1'b0;
                        traco <= 1'b0;
                        // The last element is followed by the character gap instead of a space.
                        if (sym_idx == 3'd4) begin
                            state <= S_GAP;
                            timer <= GAP_LOAD;
                        end else begin
                            state <= S_SPACE;
                            timer <= DOT_LOAD;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                        ponto <= pat[0];
                        traco <= ~pat[0];
                    end
                end
                S_SPACE: begin
                    if (timer == '0) begin
                        sym_idx <= sym_idx + 3'd1;
                        pat     <= {1'b0, pat[4:1]};
                        timer   <= pat[1] ? DOT_LOAD : DASH_LOAD;
                        state   <= S_MARK;
                        tone    <= 1'b1;
                        ponto   <= pat[1];
                        traco   <= ~pat[1];
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
                        seq.done <= 1'b1;
`ifdef MORSE_LOOP_EN
                        // Replay straight into MARK so busy never drops between looped characters.
                        if (loop_en) begin
                            pat     <= pat_orig;
                            sym_idx <= 3'd0;
                            timer   <= pat_orig[0] ? DOT_LOAD : DASH_LOAD;
                            state   <= S_MARK;
                            tone    <= 1'b1;
                            ponto   <= pat_orig[0];
                            traco   <= ~pat_orig[0];
                        end else
`endif
                        begin
                            state    <= S_IDLE;
                            sym_idx  <= 3'd0;
                            seq.busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
